// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared BNN types and constants for the feature-map collector
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fmap_state_t;

    localparam int DW_DEF     = 32;
    localparam int MAP0_WORDS = 576;
    localparam int MAP1_WORDS = 64;
    localparam int COLS0_DEF  = 24;
    localparam int COLS1_DEF  = 8;

    function automatic int unsigned map_words(input logic mode);
        return mode ? MAP1_WORDS : MAP0_WORDS;
    endfunction

endpackage

// File: rtl/fmap_collector_if.sv
// rtl/fmap_collector_if.sv - conv result input and replay output stream bundle
interface fmap_collector_if #(parameter int DW = bnn_pkg::DW_DEF);
    logic          in_valid;
    logic          in_done;
    logic [DW-1:0] din;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dout;
    logic          out_last;
    logic          out_row_end;

    modport master (
        output in_valid, in_done, din, out_ready,
        input  out_valid, dout, out_last, out_row_end
    );

    modport slave (
        input  in_valid, in_done, din, out_ready,
        output out_valid, dout, out_last, out_row_end
    );
endinterface

// File: rtl/fmap_ram.sv
// rtl/fmap_ram.sv - simple dual-port synchronous RAM, one-cycle read latency
module fmap_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 576,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fmap_collector.sv
// rtl/fmap_collector.sv - stores one conv feature map and replays it in raster order
// Optional: FMAP_BINARIZE_EN replaces replayed words by their sign activation.
module fmap_collector
    import bnn_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = MAP0_WORDS,
    parameter int COLS0 = COLS0_DEF,
    parameter int COLS1 = COLS1_DEF,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    fmap_collector_if.slave      bus,
    input  logic                 state,
    input  logic                 clr,
    input  logic                 rd_start,
    output logic                 full,
    output logic [AW-1:0]        count,
    output logic                 err
);

    fmap_state_t   fsm_q, fsm_d;
    logic          mode_q;
    logic [AW-1:0] count_q, count_nxt;
    logic          err_q;

    logic [AW-1:0] rd_idx_q, rd_col_q, cols_m1;
    logic          rv_q, r_last_q, r_row_q;
    logic          ov_q, o_last_q, o_row_q;
    logic [DW-1:0] od_q;
    logic          sv_q, s_last_q, s_row_q;
    logic [DW-1:0] sd_q;
    logic [DW-1:0] ram_rdata;

    logic          accept, drop_err, len_err, issue, pop, last_pop, mode_eff;
    logic [1:0]    pending;

    assign pop      = ov_q && bus.out_ready;
    assign last_pop = pop && o_last_q;
    assign cols_m1  = mode_q ? AW'(COLS1 - 1) : AW'(COLS0 - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        if (clr) begin
            fsm_d = ST_IDLE;
        end else begin
            case (fsm_q)
                ST_IDLE:  if (bus.in_valid) fsm_d = bus.in_done ? ST_HOLD : ST_FILL;
                ST_FILL:  if (bus.in_done)  fsm_d = ST_HOLD;
                ST_HOLD:  if (rd_start)     fsm_d = ST_DRAIN;
                ST_DRAIN: if (last_pop)     fsm_d = ST_IDLE;
                default:                    fsm_d = ST_IDLE;
            endcase
        end
    end

    // Reads are issued only while the two output slots can absorb the word in flight.
    always_comb begin
        accept    = 1'b0;
        drop_err  = 1'b0;
        len_err   = 1'b0;
        issue     = 1'b0;
        full      = 1'b0;
        mode_eff  = (fsm_q == ST_IDLE) ? state : mode_q;
        pending   = 2'(ov_q) + 2'(sv_q) + 2'(rv_q) - 2'(pop);
        accept    = bus.in_valid &&
                    ((fsm_q == ST_IDLE) || ((fsm_q == ST_FILL) && (count_q != AW'(DEPTH))));
        drop_err  = bus.in_valid && !accept;
        count_nxt = count_q + AW'(accept);
        if ((fsm_d == ST_HOLD) && (fsm_q != ST_HOLD)) begin
            len_err = (32'(count_nxt) != map_words(mode_eff));
        end
        if ((fsm_q == ST_DRAIN) && (rd_idx_q != count_q) && (pending <= 2'd1)) begin
            issue = 1'b1;
        end
        full = (fsm_q == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (clr) begin
            mode_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((fsm_q == ST_IDLE) && accept) begin
                mode_q <= state;
            end
            if (last_pop) begin
                count_q <= '0;
            end else begin
                count_q <= count_nxt;
            end
            if (drop_err || len_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_idx_q <= '0;
            rd_col_q <= '0;
            rv_q     <= 1'b0;
            r_last_q <= 1'b0;
            r_row_q  <= 1'b0;
        end else if (clr) begin
            rd_idx_q <= '0;
            rd_col_q <= '0;
            rv_q     <= 1'b0;
            r_last_q <= 1'b0;
            r_row_q  <= 1'b0;
        end else begin
            rv_q <= issue;
            if ((fsm_q == ST_HOLD) && rd_start) begin
                rd_idx_q <= '0;
                rd_col_q <= '0;
            end else if (issue) begin
                rd_idx_q <= rd_idx_q + AW'(1);
                rd_col_q <= (rd_col_q == cols_m1) ? '0 : rd_col_q + AW'(1);
                r_last_q <= (rd_idx_q == count_q - AW'(1));
                r_row_q  <= (rd_col_q == cols_m1);
            end
        end
    end

    // Output register plus one skid entry: RAM data lands in the skid when the head is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ov_q <= 1'b0; o_last_q <= 1'b0; o_row_q <= 1'b0; od_q <= '0;
            sv_q <= 1'b0; s_last_q <= 1'b0; s_row_q <= 1'b0; sd_q <= '0;
        end else if (clr) begin
            ov_q <= 1'b0; o_last_q <= 1'b0; o_row_q <= 1'b0; od_q <= '0;
            sv_q <= 1'b0; s_last_q <= 1'b0; s_row_q <= 1'b0; sd_q <= '0;
        end else if (!ov_q || pop) begin
            if (sv_q) begin
                ov_q     <= 1'b1;
                od_q     <= sd_q;
                o_last_q <= s_last_q;
                o_row_q  <= s_row_q;
                sv_q     <= rv_q;
                if (rv_q) begin
                    sd_q     <= ram_rdata;
                    s_last_q <= r_last_q;
                    s_row_q  <= r_row_q;
                end
            end else if (rv_q) begin
                ov_q     <= 1'b1;
                od_q     <= ram_rdata;
                o_last_q <= r_last_q;
                o_row_q  <= r_row_q;
            end else begin
                ov_q <= 1'b0;
            end
        end else if (rv_q) begin
            sv_q     <= 1'b1;
            sd_q     <= ram_rdata;
            s_last_q <= r_last_q;
            s_row_q  <= r_row_q;
        end
    end

    fmap_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (count_q),
        .wdata (bus.din),
        .re    (issue),
        .raddr (rd_idx_q),
        .rdata (ram_rdata)
    );

    assign bus.out_valid   = ov_q;
    assign bus.out_last    = ov_q && o_last_q;
    assign bus.out_row_end = ov_q && o_row_q;
`ifdef FMAP_BINARIZE_EN
    assign bus.dout = {{(DW-1){1'b0}}, ov_q & ~od_q[DW-1]};
`else
    assign bus.dout = od_q;
`endif
    assign count = count_q;
    assign err   = err_q;

endmodule

// File: tb/tb_fmap_collector.sv
// tb/tb_fmap_collector.sv - scoreboard bench for fmap_collector fill, replay and error paths
module tb_fmap_collector;

    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       state = 1'b0, clr = 1'b0, rd_start = 1'b0;
    logic       full, err;
    logic [9:0] count;

    logic       s_state = 1'b0, s_clr = 1'b0, s_rd_start = 1'b0;
    logic       s_full, s_err;
    logic [6:0] s_count;

    fmap_collector_if #(.DW(DW)) bus ();
    fmap_collector_if #(.DW(DW)) bus_s ();

    always #5 clk = ~clk;

    fmap_collector #(.DW(DW)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .state(state), .clr(clr),
        .rd_start(rd_start), .full(full), .count(count), .err(err)
    );

    fmap_collector #(.DW(DW), .DEPTH(64), .AW(7)) dut_s (
        .clk(clk), .rstn(rstn), .bus(bus_s), .state(s_state), .clr(s_clr),
        .rd_start(s_rd_start), .full(s_full), .count(s_count), .err(s_err)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic          row;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] w);
`ifdef FMAP_BINARIZE_EN
        return {{(DW-1){1'b0}}, ~w[DW-1]};
`else
        return w;
`endif
    endfunction

    task automatic push_map(input int n, input int base, input int cols);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d    = exp_word(32'(base + i));
            e.last = (i == n - 1);
            e.row  = (((i + 1) % cols) == 0);
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstn && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_extra_beat", 1, 0);
            end else begin
                e = sb.pop_front();
                check("dout", bus.dout, e.d);
                check("out_last", bus.out_last, e.last);
                check("out_row_end", bus.out_row_end, e.row);
            end
        end
    end

    task automatic send_map(input logic mode, input int n, input int base, input int done_at);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_done  = (i == done_at);
            bus.din      = 32'(base + i);
            state        = mode;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_done  = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic replay(input int n, input bit rnd, input int inject_at, input string tag);
        int lat, cyc;
        bus.out_ready = 1'b1;
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            lat++;
        end
        check({tag, "_first_valid_latency"}, lat, 2);
        cyc = 0;
        while (sb.size() > 0 && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid = (cyc == inject_at);
        end
        bus.in_valid = 1'b0;
        check({tag, "_drained"}, sb.size(), 0);
        if (!rnd) check({tag, "_back_to_back_cycles"}, cyc, n);
        check({tag, "_out_valid_after"}, bus.out_valid, 0);
        check({tag, "_count_after"}, count, 0);
        check({tag, "_full_after"}, full, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_done = 1'b0; bus.din = '0; bus.out_ready = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_done = 1'b0; bus_s.din = '0; bus_s.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_flags", {bus.out_last, bus.out_row_end}, 0);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        send_map(1'b0, 576, 0, 575);
        check("m0_full", full, 1);
        check("m0_count", count, 576);
        check("m0_err", err, 0);
        push_map(576, 0, 24);
        replay(576, 1'b0, -1, "m0");

        send_map(1'b1, 64, -32, 63);
        check("m1_count", count, 64);
        check("m1_err", err, 0);
        push_map(64, -32, 8);
        replay(64, 1'b1, 10, "m1rnd");
        check("drain_overrun_err", err, 1);
        pulse_clr();
        check("clr_err", err, 0);

        send_map(1'b1, 40, 100, 39);
        check("short_full", full, 1);
        check("short_count", count, 40);
        check("short_err", err, 1);
        push_map(40, 100, 8);
        replay(40, 1'b1, -1, "short");
        pulse_clr();

        send_map(1'b1, 70, 0, -1);
        bus.in_done = 1'b1;
        @(posedge clk); #1;
        bus.in_done = 1'b0;
        check("long_full", full, 1);
        check("long_count", count, 70);
        check("long_err", err, 1);
        pulse_clr();

        send_map(1'b1, 64, 7, 63);
        check("hold_err_before", err, 0);
        bus.in_valid = 1'b1; bus.din = 32'hdead_beef;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("hold_overrun_err", err, 1);
        check("hold_overrun_count", count, 64);
        check("hold_overrun_full", full, 1);
        push_map(64, 7, 8);
        replay(64, 1'b0, -1, "hold");
        pulse_clr();

        send_map(1'b0, 300, 0, -1);
        pulse_clr();
        check("clr_fill_count", count, 0);
        check("clr_fill_err", err, 0);
        check("clr_fill_full", full, 0);
        send_map(1'b0, 576, 5000, 575);
        check("m0b_err", err, 0);
        push_map(576, 5000, 24);
        replay(576, 1'b0, -1, "m0b");

        send_map(1'b1, 64, 0, 63);
        push_map(64, 0, 8);
        bus.out_ready = 1'b1;
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_drain_out_valid", bus.out_valid, 0);
        check("rst_drain_dout", bus.dout, 0);
        check("rst_drain_count", count, 0);
        check("rst_drain_full", full, 0);
        sb.delete();
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 65; i++) begin
            bus_s.in_valid = 1'b1;
            bus_s.din      = 32'(i);
            s_state        = 1'b1;
            @(posedge clk); #1;
        end
        bus_s.in_valid = 1'b0;
        check("depth_ovf_count", s_count, 64);
        check("depth_ovf_err", s_err, 1);
        check("depth_ovf_full", s_full, 0);
        bus_s.in_done = 1'b1;
        @(posedge clk); #1;
        bus_s.in_done = 1'b0;
        check("depth_ovf_hold_full", s_full, 1);
        check("depth_ovf_hold_count", s_count, 64);
        check("depth_ovf_out_idle",
              {bus_s.out_valid, bus_s.out_last, bus_s.out_row_end, bus_s.dout}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fmap_collector.md
Name: fmap_collector

Overview:
- Receives the conv_mix result stream (dout/ovalid/done) and stores one complete feature map in on-chip RAM.
- Replays the stored map in raster order to the next BNN stage over a valid/ready stream.
- Feature-map size is selected by the layer mode bit `state`: 0 = 24x24 (576 words), 1 = 8x8 (64 words).
- Also checks the map length and reports overflow/underrun.

Parameters:
- DW, 32, result word width (signed two's complement)
- DEPTH, 576, RAM words; must be >= largest map
- COLS0, 24, row length in mode 0
- COLS1, 8, row length in mode 1
- AW, 10, address/count width; must satisfy 2^AW > DEPTH

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- state  input  1  layer mode; sampled on the first accepted write of a map
- in_valid  input  1  conv result valid (conv_mix ovalid)
- in_done  input  1  last result of map (conv_mix done); qualified by in_valid
- din  input  DW  conv result
- clr  input  1  synchronous abort; returns to IDLE, drops contents
- rd_start  input  1  request replay of stored map (pulse)
- out_valid  output  1  replay data valid
- out_ready  input  1  downstream accepts
- dout  output  DW  replay data
- out_last  output  1  final word of map, qualified by out_valid
- out_row_end  output  1  last word of a row, qualified by out_valid
- full  output  1  complete map stored (HOLD state)
- count  output  AW  words currently stored
- err  output  1  sticky error; cleared by clr or reset

Behaviour:
- Reset: all outputs 0; FSM = IDLE; write and read pointers = 0.
- FSM: IDLE -> FILL -> HOLD -> DRAIN -> IDLE.
- IDLE:
  - in_valid=1 writes din to mem[0], latches mode=state, count=1, goes to FILL.
  - If in_done is also 1, goes directly to HOLD.
- FILL:
  - Each in_valid cycle writes mem[count] and increments count.
  - in_valid && in_done writes the final word, then goes to HOLD.
  - in_done without in_valid: goes to HOLD with no write.
- Write timing: no backpressure on the input side; every in_valid beat must be accepted.
- Overflow: an in_valid beat when count==DEPTH is dropped and sets err; FSM stays in FILL.
- Length check on entering HOLD: expected = 576 (mode 0) or 64 (mode 1). count != expected sets err. The map is still held and readable.
- HOLD:
  - full=1; count is stable.
  - rd_start goes to DRAIN with read pointer = 0.
  - in_valid in HOLD is dropped and sets err (overrun).
- DRAIN:
  - RAM read is synchronous. The first out_valid appears exactly 2 cycles after the rd_start sample edge.
  - A beat transfers when out_valid && out_ready.
  - With out_ready held high, beats are back to back (one per cycle, no bubbles). This needs a 2-entry prefetch/skid.
  - dout and the flags hold stable while out_valid && !out_ready.
  - out_row_end=1 when (index+1) % COLS == 0, where COLS = COLS0 or COLS1 per the latched mode.
  - out_last=1 on index count-1.
  - After the last beat transfers: IDLE, count=0, full=0, out_valid=0 next cycle.
  - in_valid during DRAIN is dropped and sets err.
- rd_start outside HOLD is ignored.
- clr has priority over everything in any state: next cycle IDLE, count=0, out_valid=0, err=0.
- Reset mid-operation: same effect as clr, but asynchronous. RAM contents are don't-care.
- No arithmetic on data except under the optional feature; din is passed bit-exact.

Optional Feature:
- Macro: FMAP_BINARIZE_EN.
- Defined: dout = {{DW-1{1'b0}}, ~word[DW-1]}, i.e. sign activation; 1 when the stored value >= 0, 0 when negative. Binarization is applied at the replay output; RAM keeps full words.
- Undefined: dout = stored word unchanged.

Decomposition:
- Shared package bnn_pkg holds:
  - FSM state encoding (IDLE/FILL/HOLD/DRAIN)
  - MAP0_WORDS=576, MAP1_WORDS=64
  - COLS0/COLS1 defaults
  - DW default
- One sub-module: fmap_ram, a simple dual-port synchronous RAM with 1-cycle read latency, DEPTH x DW.
- The FSM, counters and prefetch logic stay in fmap_collector.

Test Plan:
- Mode 0, 576 beats din=i, done on beat 575 with in_valid -> full=1, count=576, err=0. rd_start with out_ready=1 -> 576 back-to-back beats 0..575, first out_valid 2 cycles after rd_start. out_row_end on 23,47,...,575; out_last on 575.
- Mode 1, 64 beats din=-32+i, random out_ready 50% -> sequence -32..31 exact, no duplicates/drops, out_row_end every 8th word. With FMAP_BINARIZE_EN: dout 0 for the first 32 words, 1 for the last 32.
- Mode 1 with done on beat 40 -> HOLD, count=40, err=1; replay delivers 40 words, out_last on word 39.
- Mode 1 with 70 beats, no done, then done-only pulse -> overflow past DEPTH? No: count=70 > 64 -> err=1 at HOLD. Separately, DEPTH=64 build: beat 65 dropped, err=1.
- in_valid pulse during HOLD and during DRAIN -> err=1, count and replay data unchanged.
- clr asserted mid-FILL at beat 300 -> IDLE next cycle, count=0, err=0. Then a full 576-beat map replays correctly. rstn pulsed mid-DRAIN -> all outputs 0 immediately.
